mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter and sequencer for the CPU's single shared memory port. Up to four requesters (instruction fetch, load/store, debug, DMA) compete for the port. The block drives the 2-bit select of the `data_4_to1` address/write-data mux in front of the port. It grants one requester at a time, holds the grant until the memory signals completion or a timeout fires, then rotates priority.

## Interface
Parameters:
- `MAX_WAIT`, default 15: cycles a grant may wait for `mem_ready` before a forced release. Legal range 1..255.
- `CNT_W`, default 8: width of the wait counter. Must satisfy MAX_WAIT < 2^CNT_W.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `req`: input, 4 bits. Level request per requester; bit i is requester i.
- `mem_ready`: input, 1 bit. Memory completion strobe for the current transaction.
- `grant`: output, 4 bits. One-hot grant, registered.
- `sel`: output, 2 bits. Encoded index of the granted requester; wired to the mux `Selt`.
- `busy`: output, 1 bit. High while in GRANT.
- `done`: output, 1 bit. One-cycle pulse when a transaction completes normally.
- `timeout`: output, 1 bit. One-cycle pulse when a grant is force-released.

## Operation
- The FSM has two states, IDLE and GRANT.
- Round-robin pointer `ptr` (2 bits) names the highest-priority requester. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- **IDLE:**
  - If `req` ≠ 0, pick the first requester i in search order and load `grant` = 1<<i, `sel` = i, wait counter = 0. Go to GRANT.
  - If `req` = 0, stay in IDLE.
- **GRANT:**
  - If `mem_ready` = 1, pulse `done`, set ptr = sel+1 (mod 4), clear `grant`, go to IDLE.
  - Else if the wait counter = MAX_WAIT−1, pulse `timeout`, set ptr = sel+1, clear `grant`, go to IDLE.
  - Else increment the wait counter.
- A requester that drops `req` while granted does not end the grant. Only `mem_ready` or a timeout releases it.
- `mem_ready` has priority over timeout when both occur in the same cycle. Only `done` pulses.
- `mem_ready` seen in IDLE is ignored.
- `sel` holds its last value in IDLE so the mux output stays stable. `grant` is 0 in IDLE.
- Reset values: state IDLE, ptr = 0, `grant` = 0, `sel` = 0, `busy` = 0, `done` = 0, `timeout` = 0, wait counter = 0.
- Reset asserted mid-transaction clears all state immediately, with no `done` or `timeout` pulse.

## Timing
- Request to grant: `req` sampled in IDLE at edge N gives `grant`/`sel` valid after edge N (1 cycle).
- Release takes 1 cycle: `mem_ready` sampled at edge M clears `grant` after edge M. `done` is high during the cycle after edge M.
- One mandatory IDLE cycle separates grants. Back-to-back throughput is therefore one transaction per (wait + 2) cycles.
- With `mem_ready` never arriving, a timeout releases the grant MAX_WAIT cycles after the grant is asserted.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state encoding constants: IDLE = 1'b0, GRANT = 1'b1;
  - requester index constants: REQ_IFETCH = 0, REQ_LSU = 1, REQ_DBG = 2, REQ_DMA = 3.
- One sub-module, `rr_pick4`: combinational. Takes `req[3:0]` and `ptr[1:0]` and returns `idx[1:0]` and `any`.
- The top instantiates `rr_pick4` plus the FSM, counter and pointer registers.
- The `data_4_to1` mux stays outside this block.

## Test plan
- **Reset:** hold `rst_n` = 0 with `req` = 4'b1111. Required: `grant` = 0, `sel` = 0, `busy` = 0. Release reset: `grant` = 4'b0001 after one edge.
- **Round-robin:** hold `req` = 4'b1111 and pulse `mem_ready` 2 cycles after each grant. Required grant sequence 0001, 0010, 0100, 1000, 0001, with one `done` pulse per grant.
- **Skip and priority:** set ptr = 1 via one completed grant to 0, then `req` = 4'b1001. Required: `grant` = 1000 (`sel` = 3), and after it completes, `grant` = 0001.
- **Timeout:** with MAX_WAIT = 4, `req` = 4'b0100, and `mem_ready` held 0, required: the grant lasts 4 cycles, `timeout` pulses once, and the next grant goes to requester 2 again after one IDLE cycle.
- **Simultaneous events:** `mem_ready` = 1 on the timeout cycle. Required: `done` = 1, `timeout` = 0.
- **Abort and reset:** drop `req` mid-grant and check the grant holds until `mem_ready`. Then assert `rst_n` = 0 mid-grant and check all outputs are 0 asynchronously, with no pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and requester indices.
// Pure declarations, no logic.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] REQ_IFETCH = 2'd0;
  localparam logic [1:0] REQ_LSU    = 2'd1;
  localparam logic [1:0] REQ_DBG    = 2'd2;
  localparam logic [1:0] REQ_DMA    = 2'd3;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin pick of one of four requesters, starting the search at ptr.
// Purely combinational; no backpressure.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;

  // rot[k] is requester (ptr + k) mod 4, so the lowest set bit is the winner
  assign dbl = {req, req};
  assign rot = dbl[ptr +: 4];

  always_comb begin
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
  end

  assign idx = ptr + off;
  assign any = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared memory port; grant held until mem_ready or timeout.
// Grant 1 cycle after request, release 1 cycle after mem_ready; one idle cycle between grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mem_ready,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       pick_idx;
  logic             pick_any;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      grant    <= 4'd0;
      sel      <= 2'd0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant    <= 4'b0001 << pick_idx;
            sel      <= pick_idx;
            wait_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // completion wins over a timeout landing on the same cycle
          if (mem_ready) begin
            done  <= 1'b1;
            ptr   <= sel + 2'd1;
            grant <= 4'd0;
            state <= IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            timeout <= 1'b1;
            ptr     <= sel + 2'd1;
            grant   <= 4'd0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grant/release events,
// a negedge monitor reconstructs events from the outputs and compares them in order.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       mem_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic       timeout;

  int n_pass  = 0;
  int n_total = 0;

  mem_port_arbiter #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mem_ready (mem_ready),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // kind: 0 = grant start, 1 = done, 2 = timeout, 3 = both pulses (never legal)
  typedef struct {
    logic [1:0] kind;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    int         len;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic exp_start(input logic [3:0] g, input logic [1:0] s, input int gap);
    ev_t e;
    e.kind = 2'd0; e.gnt = g; e.sel = s; e.busy = 1'b1; e.len = gap;
    exp_q.push_back(e);
  endtask

  task automatic exp_rel(input logic [1:0] k, input logic [3:0] g, input int len);
    ev_t e;
    e.kind = k; e.gnt = g; e.sel = 2'd0; e.busy = 1'b0; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic compare_ev(input ev_t a);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got kind %0d grant %b, expected no event at %0t",
               a.kind, a.gnt, $time);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", a.kind, e.kind);
      check("ev_grant", a.gnt, e.gnt);
      check("ev_sel", a.sel, e.sel);
      check("ev_busy", a.busy, e.busy);
      if (e.len >= 0) check(a.kind == 2'd0 ? "idle_gap" : "grant_len", a.len, e.len);
    end
  endtask

  // Monitor: grant_len counts sampled cycles with grant high, idle_len cycles with it low.
  logic [3:0] prev_grant = 4'd0;
  int grant_len = 0;
  int idle_len  = 0;

  always @(negedge clk) begin
    ev_t a;
    if (done || timeout) begin
      a.kind = {timeout, done}; a.gnt = prev_grant; a.sel = 2'd0; a.busy = busy; a.len = grant_len;
      compare_ev(a);
    end
    if (grant != 4'd0 && prev_grant == 4'd0) begin
      a.kind = 2'd0; a.gnt = grant; a.sel = sel; a.busy = busy; a.len = idle_len;
      compare_ev(a);
    end
    if (grant != 4'd0) grant_len = (prev_grant == 4'd0) ? 1 : grant_len + 1;
    else               idle_len  = (prev_grant != 4'd0) ? 1 : idle_len + 1;
    prev_grant = grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (grant == 4'd0 && n < 20) begin
      tick();
      n++;
    end
    if (grant == 4'd0) begin
      n_total++;
      $display("FAIL %s: no grant within %0d cycles", name, n);
    end
  endtask

  // Wait for a grant, switch req, hold mem_ready low w cycles, then pulse it for one cycle.
  task automatic serve(input int w, input logic [3:0] nreq, input logic [3:0] g, input int len);
    exp_rel(2'd1, g, len);
    wait_grant("serve_wait");
    req = nreq;
    repeat (w) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    req       = 4'b1111;
    mem_ready = 1'b0;
    repeat (3) tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_sel", sel, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {done, timeout}, 2'b00);

    exp_start(4'b0001, 2'd0, -1);
    rst_n = 1'b1;
    tick();
    check("first_grant", grant, 4'b0001);

    // round robin with every requester active
    serve(2, 4'b1111, 4'b0001, 3); exp_start(4'b0010, 2'd1, 1);
    serve(2, 4'b1111, 4'b0010, 3); exp_start(4'b0100, 2'd2, 1);
    serve(2, 4'b1111, 4'b0100, 3); exp_start(4'b1000, 2'd3, 1);
    serve(2, 4'b1111, 4'b1000, 3); exp_start(4'b0001, 2'd0, 1);
    // ptr lands on 1; req 1001 must skip 1 and 2
    serve(2, 4'b1001, 4'b0001, 3); exp_start(4'b1000, 2'd3, 1);
    serve(2, 4'b1001, 4'b1000, 3); exp_start(4'b0001, 2'd0, 1);
    serve(2, 4'b0100, 4'b0001, 3); exp_start(4'b0100, 2'd2, 1);

    // timeout: mem_ready never arrives, grant lasts MAX_WAIT cycles, then re-grant to 2
    exp_rel(2'd2, 4'b0100, 4);
    exp_start(4'b0100, 2'd2, 1);
    wait_grant("to_wait_grant");
    n = 0;
    while (grant != 4'd0 && n < 20) begin
      tick();
      n++;
    end
    check("to_released", grant, 4'b0000);

    // mem_ready on the timeout cycle: done only
    serve(3, 4'b0010, 4'b0100, 4); exp_start(4'b0010, 2'd1, 1);

    // req dropped immediately after grant; grant must persist until mem_ready
    serve(2, 4'b0000, 4'b0010, 3);
    check("idle_grant", grant, 4'b0000);
    check("idle_sel_hold", sel, 2'd1);
    check("idle_busy", busy, 1'b0);
    repeat (2) tick();
    check("idle_stay", grant, 4'b0000);
    check("idle_sel_hold2", sel, 2'd1);

    // asynchronous reset in the middle of a grant
    req = 4'b1000;
    exp_start(4'b1000, 2'd3, -1);
    wait_grant("abort_wait");
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", grant, 4'b0000);
    check("arst_sel", sel, 2'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_pulses", {done, timeout}, 2'b00);
    req = 4'b0000;
    repeat (2) tick();
    check("arst_hold", {grant, busy, done, timeout}, 7'd0);
    rst_n = 1'b1;
    tick();

    // ptr must be back at 0: req 0110 goes to requester 1
    req = 4'b0110;
    exp_start(4'b0010, 2'd1, -1);
    serve(0, 4'b0000, 4'b0010, 1);
    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
